// File: rtl/seg_pkg.sv
// Shared constants and types for the six-digit multiplexed 7-segment display path.
// Segment patterns are active-low and ordered {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_BLANK = 4'hF;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    SLOT_GUARD,
    SLOT_DRIVE
  } slot_state_t;

endpackage

// File: rtl/bcd_seg_decode.sv
// BCD nibble to active-low 7-segment pattern; purely combinational, no backpressure.
// A..E render as a dash, F renders blank.
module bcd_seg_decode
  import seg_pkg::*;
(
  input  bcd_t       digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA, 4'hB, 4'hC, 4'hD, 4'hE: seg = SEG_DASH;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Scans six shadowed BCD digits onto one 7-segment bus with a blanking guard per slot.
// seg/dp/an lag the slot decision by one registered cycle; free-running, no backpressure.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int GUARD    = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] d5,
  input  logic [3:0] d6,
  input  logic [1:0] ampm,
  input  logic       lz_en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       frame_start
);

  localparam int            CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
  localparam logic [2:0]    IDX_LAST  = 3'(NUM_DIGITS - 1);
  localparam logic [2:0]    IDX_AMPM  = 3'(NUM_DIGITS - 2);

  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  slot_state_t   state, state_nxt;

  bcd_t          shadow [NUM_DIGITS];
  logic          sh_pm;
  logic          sh_lz;

  logic          snap;
  bcd_t          cur_digit;
  logic [6:0]    dec_seg;
  logic [6:0]    seg_nxt;
  logic [5:0]    an_nxt;
  logic          dp_nxt;
  logic          unused_ampm_hi;

  assign unused_ampm_hi = ampm[1];
  assign snap           = (cnt == '0) && (idx == '0);
  assign cur_digit      = shadow[idx];

  bcd_seg_decode u_decode (
    .digit (cur_digit),
    .seg   (dec_seg)
  );

  always_comb begin
    cnt_nxt = cnt + CW'(1);
    idx_nxt = idx;
    if (cnt == CNT_LAST) begin
      cnt_nxt = '0;
      idx_nxt = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    end
  end

  // The state always mirrors cnt < GUARD for the current cycle, so it is derived from cnt_nxt.
  always_comb begin
    state_nxt = (cnt_nxt < CNT_GUARD) ? SLOT_GUARD : SLOT_DRIVE;
    an_nxt    = '1;
    seg_nxt   = SEG_BLANK;
    dp_nxt    = 1'b1;
    case (state)
      SLOT_GUARD: begin
        an_nxt  = '1;
        seg_nxt = SEG_BLANK;
        dp_nxt  = 1'b1;
      end
      SLOT_DRIVE: begin
        an_nxt  = ~(6'b000001 << idx);
        seg_nxt = dec_seg;
        // Suppressed hours-tens keeps its anode on so every slot has the same duty cycle.
        if (idx == IDX_LAST && sh_lz && shadow[NUM_DIGITS-1] == 4'h0) begin
          seg_nxt = SEG_BLANK;
        end
        dp_nxt  = ~(idx == IDX_AMPM && sh_pm);
      end
      default: begin
        an_nxt  = '1;
        seg_nxt = SEG_BLANK;
        dp_nxt  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      state       <= SLOT_GUARD;
      sh_pm       <= 1'b0;
      sh_lz       <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= BCD_BLANK;
      end
      an          <= '1;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      state       <= state_nxt;
      an          <= an_nxt;
      seg         <= seg_nxt;
      dp          <= dp_nxt;
      frame_start <= snap;
      if (snap) begin
        shadow[0] <= d1;
        shadow[1] <= d2;
        shadow[2] <= d3;
        shadow[3] <= d4;
        shadow[4] <= d5;
        shadow[5] <= d6;
        sh_pm     <= ampm[0];
        sh_lz     <= lz_en;
      end
    end
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Display end of the clock datapath. Consumes the six BCD digit nibbles and the AM/PM flag produced by the time/setting block; nibble 4'hF means "blank" and is used for setting-mode blink.
- Time-multiplexes the six digits onto one shared 7-segment bus with one-hot anode select.
- Adds an anti-ghosting guard interval between digits, a per-frame input snapshot to prevent tearing, and optional hour leading-zero suppression.

Parameters:
- SCAN_DIV, 1000: clock cycles per digit slot; legal range ≥ GUARD+2.
- GUARD, 50: cycles at the start of each slot during which all anodes are off; legal range ≥ 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- d1..d6  in  4 each  BCD digits: d1 = seconds ones … d6 = hours tens; 4'hF = blank.
- ampm  in  2  bit0 = 1 means PM; bit1 is ignored.
- lz_en  in  1  blanks d6 when d6 == 0.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  6  anode select, active-low, one-hot; an[0] = d1 (rightmost).
- frame_start  out  1  one-cycle pulse when a new snapshot is taken.

Behaviour:
- Reset state: cnt=0, idx=0, shadow digits=4'hF, shadow ampm=0, an=6'b111111, seg=7'b1111111, dp=1, frame_start=0.
- Counters: cnt runs 0..SCAN_DIV-1 and wraps to 0. On wrap, idx advances 0..5 and 5 wraps to 0. The first cycle after the reset-release edge has cnt=0, idx=0.
- Snapshot: on the edge ending any cycle with cnt==0 && idx==0, d1..d6, ampm and lz_en load into shadow registers. frame_start is high during the following cycle only. Input changes at any other time affect nothing until the next snapshot.
- Slot FSM, decided per cycle from cnt:
  - GUARD (cnt < GUARD): an all 1, seg 7'h7F, dp 1.
  - DRIVE (cnt ≥ GUARD): an[idx]=0 and all other anodes 1; seg = decode(shadow[idx]); dp as below.
- Output latency: seg/dp/an are registered and show the decision for the previous cycle's cnt/idx (exactly 1-cycle lag). Outputs never glitch within a cycle.
- Decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - 4'hA..4'hE: dash 0111111.
  - 4'hF: blank 1111111.
- Leading zero: if shadow lz_en=1 and shadow d6==0, slot 5 drives seg=1111111. The anode is still asserted, preserving duty cycle.
- dp: 0 only in DRIVE of slot 4 (d5) when shadow ampm[0]=1; otherwise 1.
- Guarantees: never more than one anode low in any cycle. At every slot boundary, at least GUARD consecutive cycles have an=6'b111111.
- Reset mid-frame: at the next edge all state returns to reset values and scanning restarts at slot 0. The reset cycle itself produces no partial digit.

Decomposition:
- Package seg_pkg holds:
  - SEG_0..SEG_9, SEG_DASH, SEG_BLANK 7-bit constants.
  - BCD_BLANK = 4'hF.
  - NUM_DIGITS = 6.
- Sub-module bcd_seg_decode: purely combinational nibble → 7-bit active-low pattern, instantiated once on the muxed shadow digit.
- Top level holds the counters, shadow registers, slot FSM and output registers.

Test Plan:
- SCAN_DIV=8, GUARD=2, d1..d6=1,2,3,4,5,6, reset released → an[0]=0 exactly in cycles 3..8 with seg=1111001. an=111111 in cycles 1..2 and 9..10. an[1]=0 in cycles 11..16 with seg=0100100.
- Same setup, full frame → an sequence 0→5, one-hot in every DRIVE cycle. frame_start high at cycle 1 and then every 48 cycles. Period is 48 cycles.
- d3 changes 3→7 mid-frame (cycle 20) → slot 2 still shows 0110000 this frame; the next frame shows 1111000.
- d6=0 with lz_en=1 → slot 5: an[5]=0 with seg=1111111. With lz_en=0 → seg=1000000. With d6=4'hF → blank; with d6=4'hB → 0111111.
- ampm=2'b01 → dp=0 only during slot 4 DRIVE cycles. ampm=2'b10 → dp stays 1 throughout.
- rst asserted at cycle 30 for one cycle → the next cycle shows an=111111, seg=1111111, dp=1. Scanning resumes at slot 0 with cnt=0, and frame_start pulses one cycle later.
